// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and encodings for the data-memory responder.
package dmem_pkg;
    localparam int DMEM_ADDR_W = 7;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_LEN_W  = 8;
    localparam int DMEM_DEPTH  = 1 << DMEM_ADDR_W;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_LOAD = 2'b01,
        CMD_DUMP = 2'b10
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DUMP
    } state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core data port plus host LOAD/DUMP backdoor handshakes.
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int LEN_W  = DMEM_LEN_W
);
    logic              cen;
    logic              wen;
    logic              oen;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] q;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              cpu_hold;

    modport master (
        output cen, wen, oen, a, d, cmd_valid, cmd_op, cmd_base, cmd_len,
               wdata_valid, wdata, rdata_ready,
        input  q, cmd_ready, wdata_ready, rdata_valid, rdata, cpu_hold
    );

    modport slave (
        input  cen, wen, oen, a, d, cmd_valid, cmd_op, cmd_base, cmd_len,
               wdata_valid, wdata, rdata_ready,
        output q, cmd_ready, wdata_ready, rdata_valid, rdata, cpu_hold
    );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with async clear, synchronous write and combinational reads.
module dmem_array #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);
    logic [DATA_W-1:0] r_mem [1 << ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << ADDR_W); i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Port b lets a DUMP fetch its first word in the same cycle the core reads.
    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: 128x32 data memory for the core with a host LOAD/DUMP backdoor
// that stalls the core while a burst owns the array.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int LEN_W  = DMEM_LEN_W
) (
    input logic              clk,
    input logic              rst_n,
    dmem_responder_if.slave  io_mem
);
    localparam int DEPTH = 1 << ADDR_W;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_ptr, w_ptr_inc, w_waddr, w_bd_raddr;
    logic [LEN_W-1:0]  r_cnt, w_len;
    logic [DATA_W-1:0] r_rdata, w_wdata, w_core_rd, w_bd_rd;
    logic              r_rvalid, w_idle, w_we, w_accept, w_wfire, w_rfire;
    logic              w_start_load, w_start_dump;

    always_comb begin
        w_idle       = r_state == ST_IDLE;
        w_ptr_inc    = r_ptr + 1'b1;
        w_len        = (io_mem.cmd_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : io_mem.cmd_len;
        w_accept     = io_mem.cmd_valid && w_idle;
        w_start_load = w_accept && io_mem.cmd_op == CMD_LOAD && w_len != '0;
        w_start_dump = w_accept && io_mem.cmd_op == CMD_DUMP && w_len != '0;
        w_wfire      = io_mem.wdata_valid && r_state == ST_LOAD;
        w_rfire      = r_rvalid && io_mem.rdata_ready && r_state == ST_DUMP;
        w_we         = w_idle ? (!io_mem.cen && !io_mem.wen) : w_wfire;
        w_waddr      = w_idle ? io_mem.a : r_ptr;
        w_wdata      = w_idle ? io_mem.d : io_mem.wdata;
        w_bd_raddr   = w_idle ? io_mem.cmd_base : w_ptr_inc;
    end

    always_comb begin
        w_next = r_state;
        if (w_start_load) w_next = ST_LOAD;
        else if (w_start_dump) w_next = ST_DUMP;
        else if ((w_wfire || w_rfire) && r_cnt == LEN_W'(1)) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= io_mem.cmd_base;
            r_cnt <= w_len;
            if (w_start_dump) begin
                r_rdata  <= w_bd_rd;
                r_rvalid <= 1'b1;
            end
        end else if (w_wfire) begin
            r_ptr <= w_ptr_inc;
            r_cnt <= r_cnt - 1'b1;
        end else if (w_rfire) begin
            if (r_cnt == LEN_W'(1)) begin
                r_rvalid <= 1'b0;
            end else begin
                r_ptr   <= w_ptr_inc;
                r_rdata <= w_bd_rd;
                r_cnt   <= r_cnt - 1'b1;
            end
        end
    end

    dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (io_mem.a),
        .i_raddr_b (w_bd_raddr),
        .o_rdata_a (w_core_rd),
        .o_rdata_b (w_bd_rd)
    );

    assign io_mem.q           = (w_idle && !io_mem.cen && !io_mem.oen) ? w_core_rd : '0;
    assign io_mem.cmd_ready   = w_idle;
    assign io_mem.cpu_hold    = !w_idle;
    assign io_mem.wdata_ready = r_state == ST_LOAD;
    assign io_mem.rdata_valid = r_rvalid;
    assign io_mem.rdata       = r_rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bursts checked every cycle against a behavioural
// memory model, plus literal expectations on key words and handshakes.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   run_chk = 1'b0;

    logic [31:0] m_mem [128];
    bit          m_load = 1'b0;
    bit          m_dump = 1'b0;
    int          m_addr = 0;
    int          m_left = 0;
    int          m_len = 0;
    logic [31:0] dq [$];

    dmem_responder_if bus ();

    dmem_responder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_mem (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory model: a burst is just a list of addresses to fill or a list of words to emit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_load = 1'b0;
            m_dump = 1'b0;
            dq.delete();
        end else if (m_load) begin
            if (bus.wdata_valid) begin
                m_mem[m_addr] = bus.wdata;
                m_addr = (m_addr + 1) % 128;
                m_left--;
                m_load = m_left > 0;
            end
        end else if (m_dump) begin
            if (bus.rdata_ready) begin
                void'(dq.pop_front());
                m_dump = dq.size() > 0;
            end
        end else begin
            m_len = (bus.cmd_len > 8'd128) ? 128 : int'(bus.cmd_len);
            if (bus.cmd_valid && m_len > 0 && bus.cmd_op == 2'b01) begin
                m_load = 1'b1;
                m_addr = int'(bus.cmd_base);
                m_left = m_len;
            end
            if (bus.cmd_valid && m_len > 0 && bus.cmd_op == 2'b10) begin
                m_dump = 1'b1;
                for (int k = 0; k < m_len; k++) dq.push_back(m_mem[(int'(bus.cmd_base) + k) % 128]);
            end
            if (!bus.cen && !bus.wen) m_mem[bus.a] = bus.d;
        end
    end

    always @(negedge clk) begin
        if (run_chk && rst_n) begin
            chk("cmd_ready", {31'b0, bus.cmd_ready}, {31'b0, !(m_load || m_dump)});
            chk("cpu_hold", {31'b0, bus.cpu_hold}, {31'b0, m_load || m_dump});
            chk("wdata_ready", {31'b0, bus.wdata_ready}, {31'b0, m_load});
            chk("rdata_valid", {31'b0, bus.rdata_valid}, {31'b0, m_dump});
            chk("q", bus.q, (!m_load && !m_dump && !bus.cen && !bus.oen) ? m_mem[bus.a] : 32'h0);
            if (m_dump) chk("rdata", bus.rdata, dq[0]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.cen = 1'b0; bus.wen = 1'b1; bus.oen = 1'b0; bus.a = '0; bus.d = '0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_base = '0; bus.cmd_len = '0;
        bus.wdata_valid = 1'b0; bus.wdata = '0; bus.rdata_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("rst_cpu_hold", {31'b0, bus.cpu_hold}, 32'd0);
        chk("rst_wdata_ready", {31'b0, bus.wdata_ready}, 32'd0);
        chk("rst_rdata_valid", {31'b0, bus.rdata_valid}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_q", bus.q, 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        bus.cen = 1'b1;
        run_chk = 1'b1;

        bus.cen = 1'b0; bus.wen = 1'b0; bus.a = 7'd5; bus.d = 32'hDEADBEEF;
        cyc();
        bus.wen = 1'b1; bus.oen = 1'b0;
        #1 chk("core_rd_5", bus.q, 32'hDEADBEEF);
        bus.oen = 1'b1;
        #1 chk("core_rd_oen_off", bus.q, 32'h0);
        cyc();
        bus.cen = 1'b1;

        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_base = 7'd126; bus.cmd_len = 8'd4;
        cyc();
        bus.cmd_valid = 1'b0;
        chk("load_hold", {31'b0, bus.cpu_hold}, 32'd1);
        bus.cen = 1'b0; bus.wen = 1'b0; bus.a = 7'd0; bus.d = 32'h55;
        bus.wdata_valid = 1'b1; bus.wdata = 32'd1;
        cyc();
        bus.wdata = 32'd2;
        cyc();
        bus.wdata_valid = 1'b0;
        cyc();
        chk("load_gap_hold", {31'b0, bus.cpu_hold}, 32'd1);
        bus.wdata_valid = 1'b1; bus.wdata = 32'd3;
        cyc();
        bus.wdata = 32'd4;
        cyc();
        bus.wdata_valid = 1'b0; bus.wen = 1'b1; bus.oen = 1'b0;
        chk("load_done_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("load_done_hold", {31'b0, bus.cpu_hold}, 32'd0);
        bus.a = 7'd126; #1 chk("mem126", bus.q, 32'd1);
        bus.a = 7'd127; #1 chk("mem127", bus.q, 32'd2);
        bus.a = 7'd0;   #1 chk("mem0_kept", bus.q, 32'd3);
        bus.a = 7'd1;   #1 chk("mem1", bus.q, 32'd4);
        chk("model_mem0", m_mem[0], 32'd3);
        chk("model_mem127", m_mem[127], 32'd2);
        bus.cen = 1'b1;

        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_base = 7'd0; bus.cmd_len = 8'd0;
        cyc();
        chk("len0_hold", {31'b0, bus.cpu_hold}, 32'd0);
        bus.cmd_op = 2'b11; bus.cmd_len = 8'd5;
        cyc();
        chk("nop_hold", {31'b0, bus.cpu_hold}, 32'd0);
        bus.cmd_valid = 1'b0;
        bus.cen = 1'b0; bus.oen = 1'b0; bus.a = 7'd0;
        #1 chk("nop_mem0", bus.q, 32'd3);
        bus.cen = 1'b1;

        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_base = 7'd126; bus.cmd_len = 8'd4;
        bus.rdata_ready = 1'b1;
        bus.cen = 1'b0; bus.wen = 1'b0; bus.a = 7'd10; bus.d = 32'h77;
        cyc();
        bus.cmd_valid = 1'b0; bus.cen = 1'b1; bus.wen = 1'b1;
        chk("dump_valid", {31'b0, bus.rdata_valid}, 32'd1);
        chk("dump_w1", bus.rdata, 32'd1);
        cyc();
        chk("dump_w2", bus.rdata, 32'd2);
        bus.rdata_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("dump_w2_stall", bus.rdata, 32'd2);
        end
        bus.rdata_ready = 1'b1;
        cyc();
        chk("dump_w3", bus.rdata, 32'd3);
        cyc();
        chk("dump_w4", bus.rdata, 32'd4);
        cyc();
        chk("dump_end_valid", {31'b0, bus.rdata_valid}, 32'd0);
        chk("dump_end_ready", {31'b0, bus.cmd_ready}, 32'd1);
        bus.cen = 1'b0; bus.oen = 1'b0; bus.a = 7'd10;
        #1 chk("accept_cycle_write", bus.q, 32'h77);
        bus.cen = 1'b1;

        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_base = 7'd0; bus.cmd_len = 8'd200;
        cyc();
        bus.cmd_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && bus.rdata_valid; i++) begin
            n++;
            cyc();
        end
        chk("clamp_len", n, 32'd128);

        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_base = 7'd120; bus.cmd_len = 8'd8;
        cyc();
        bus.cmd_valid = 1'b0;
        cyc(); cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, bus.rdata_valid}, 32'd0);
        chk("mid_rst_hold", {31'b0, bus.cpu_hold}, 32'd0);
        chk("mid_rst_ready", {31'b0, bus.cmd_ready}, 32'd1);
        cyc();
        rst_n = 1'b1;
        bus.cen = 1'b0; bus.oen = 1'b0; bus.wen = 1'b1;
        bus.a = 7'd126; #1 chk("cleared_126", bus.q, 32'd0);
        bus.a = 7'd5;   #1 chk("cleared_5", bus.q, 32'd0);
        bus.a = 7'd10;  #1 chk("cleared_10", bus.q, 32'd0);
        cyc(); cyc();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
